run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 112 +++++++++++
 tb/tb_run_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - program launch sequencer: start hold, run timing with timeout, result handshake
module run_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter int unsigned START_HOLD     = 2,
  parameter logic [11:0] PROG0_BASE     = 12'd0,
  parameter logic [11:0] PROG1_BASE     = 12'd256,
  parameter logic [11:0] PROG2_BASE     = 12'd512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [1:0]  prog_sel,
  input  logic        core_done,
  input  logic        result_ack,
  output logic        core_start,
  output logic [11:0] core_pc_base,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] cycle_count,
  output logic        timeout,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

  state_t      state;
  logic [3:0]  hold_cnt;
  logic [15:0] count_next;
  logic [11:0] sel_base;

  assign count_next = cycle_count + 16'd1;

  always_comb begin
    sel_base = PROG0_BASE;
    case (prog_sel)
      2'd1:    sel_base = PROG1_BASE;
      2'd2:    sel_base = PROG2_BASE;
      default: sel_base = PROG0_BASE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      core_start   <= 1'b0;
      core_pc_base <= 12'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      cycle_count  <= 16'd0;
      timeout      <= 1'b0;
      error        <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (prog_sel != 2'd3) begin
              state        <= START;
              busy         <= 1'b1;
              core_start   <= 1'b1;
              core_pc_base <= sel_base;
              cycle_count  <= 16'd0;
              timeout      <= 1'b0;
              hold_cnt     <= 4'd0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        START: begin
          // core_done is deliberately not looked at here: it may be stale
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_start <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        RUN: begin
          if (core_done) begin
            state        <= REPORT;
            result_valid <= 1'b1;
          end else begin
            cycle_count <= count_next;
            if (count_next == TIMEOUT_CYCLES) begin
              timeout      <= 1'b1;
              state        <= REPORT;
              result_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (result_ack) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          core_start   <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer (default and short-timeout instances)
module tb_run_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       core_done = 1'b0;
  logic       result_ack = 1'b0;
  logic       sel = 1'b0;

  logic        d0_start, d0_busy, d0_rv, d0_to, d0_err;
  logic [11:0] d0_pc;
  logic [15:0] d0_cnt;
  logic        d1_start, d1_busy, d1_rv, d1_to, d1_err;
  logic [11:0] d1_pc;
  logic [15:0] d1_cnt;

  run_sequencer dut0 (
    .clk(clk), .reset(reset), .go(go & ~sel), .prog_sel(prog_sel),
    .core_done(core_done & ~sel), .result_ack(result_ack & ~sel),
    .core_start(d0_start), .core_pc_base(d0_pc), .busy(d0_busy),
    .result_valid(d0_rv), .cycle_count(d0_cnt), .timeout(d0_to), .error(d0_err)
  );

  run_sequencer #(.TIMEOUT_CYCLES(16'd8), .START_HOLD(3)) dut1 (
    .clk(clk), .reset(reset), .go(go & sel), .prog_sel(prog_sel),
    .core_done(core_done & sel), .result_ack(result_ack & sel),
    .core_start(d1_start), .core_pc_base(d1_pc), .busy(d1_busy),
    .result_valid(d1_rv), .cycle_count(d1_cnt), .timeout(d1_to), .error(d1_err)
  );

  logic        o_start, o_busy, o_rv, o_to, o_err;
  logic [11:0] o_pc;
  logic [15:0] o_cnt;
  assign o_start = sel ? d1_start : d0_start;
  assign o_busy  = sel ? d1_busy  : d0_busy;
  assign o_rv    = sel ? d1_rv    : d0_rv;
  assign o_to    = sel ? d1_to    : d0_to;
  assign o_err   = sel ? d1_err   : d0_err;
  assign o_pc    = sel ? d1_pc    : d0_pc;
  assign o_cnt   = sel ? d1_cnt   : d0_cnt;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] cnt;
    logic        to;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] base_of(input int p);
    case (p)
      1:       return 12'd256;
      2:       return 12'd512;
      default: return 12'd0;
    endcase
  endfunction

  // Scoreboard: each new result_valid pops the oldest expected result
  logic rv_q = 1'b0;
  always @(negedge clk) begin
    if (o_rv && !rv_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("sb_pc_base", o_pc, e.pc);
        check("sb_cycle_count", o_cnt, e.cnt);
        check("sb_timeout", o_to, e.to);
      end
    end
    rv_q = o_rv;
  end

  // done_at: RUN cycle on which core_done is raised (0 = never)
  task automatic run_prog(input int p, input int done_at, input bit stale,
                          input bit hammer, input int ack_delay);
    result_t e;
    int hold_exp, to_lim, hold, cyc;
    hold_exp = sel ? 3 : 2;
    to_lim   = sel ? 8 : 4096;
    e.pc = base_of(p);
    if (done_at == 0) begin
      e.cnt = 16'(to_lim);
      e.to  = 1'b1;
    end else begin
      e.cnt = 16'(done_at - 1);
      e.to  = 1'b0;
    end
    exp_q.push_back(e);

    go = 1'b1; prog_sel = 2'(p); core_done = stale;
    tick();
    go = 1'b0;
    check("accept_busy", o_busy, 1);
    check("accept_pc_base", o_pc, base_of(p));
    hold = 0;
    while (o_start && hold < 20) begin
      hold++;
      tick();
    end
    check("start_hold", hold, hold_exp);
    check("run_busy", o_busy, 1);

    cyc = 1;
    while (!o_rv && cyc <= 5000) begin
      core_done = (cyc == done_at);
      if (hammer) begin
        go = 1'b1; prog_sel = 2'((p + 1) % 3); result_ack = 1'b1;
      end
      tick();
      cyc++;
    end
    core_done = 1'b0; result_ack = 1'b0;
    check("run_cycles", cyc - 1, (done_at == 0) ? to_lim : done_at);
    if (hammer) check("go_ignored_run", o_pc, base_of(p));

    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("report_hold", o_rv, 1);
    end
    if (hammer) check("go_ignored_report", o_pc, base_of(p));
    result_ack = 1'b1; go = 1'b0;
    tick();
    result_ack = 1'b0;
    check("ack_rv_low", o_rv, 0);
    check("ack_idle", o_busy, 0);
    check("held_count", o_cnt, e.cnt);
    check("held_timeout", o_to, e.to);
    check("held_pc", o_pc, e.pc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, o_start, 0);
    check({tag, "_pc"}, o_pc, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_rv"}, o_rv, 0);
    check({tag, "_cnt"}, o_cnt, 0);
    check({tag, "_to"}, o_to, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int hold;
    reset = 1'b1;
    tick(); tick();
    check_reset_vals("reset");

    // go in the first cycle with reset low is accepted
    reset = 1'b0;
    run_prog(1, 37, 1'b0, 1'b0, 2);

    go = 1'b1; prog_sel = 2'd3;
    tick();
    go = 1'b0; prog_sel = 2'd0;
    check("err_pulse", o_err, 1);
    check("err_busy", o_busy, 0);
    check("err_count_kept", o_cnt, 36);
    check("err_pc_kept", o_pc, 256);
    tick();
    check("err_one_cycle", o_err, 0);
    check("err_still_idle", o_busy, 0);

    run_prog(0, 10, 1'b0, 1'b1, 0);
    run_prog(2, 1, 1'b1, 1'b0, 1);

    sel = 1'b1;
    run_prog(0, 0, 1'b0, 1'b0, 0);
    run_prog(1, 8, 1'b0, 1'b0, 0);
    sel = 1'b0;

    go = 1'b1; prog_sel = 2'd1;
    tick();
    go = 1'b0;
    hold = 0;
    while (o_start && hold < 20) begin
      hold++;
      tick();
    end
    repeat (5) tick();
    check("abort_count", o_cnt, 5);
    check("abort_busy", o_busy, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("abort");
    reset = 1'b0;
    tick();
    check("abort_no_result", o_rv, 0);
    run_prog(2, 20, 1'b0, 1'b0, 0);

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
